// File: rtl/noc_alloc_pkg.sv
// rtl/noc_alloc_pkg.sv - shared types and helpers for NoC router allocators
package noc_alloc_pkg;

    typedef enum logic {ALLOC_IDLE, ALLOC_LOCKED} alloc_state_e;

    function automatic int clog2_min1(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, first request at or after ptr
module rr_arbiter
    import noc_alloc_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx
);

    logic [PW:0]   sum;
    logic [PW-1:0] cand;
    logic          found;

    always_comb begin
        grant = '0;
        idx   = '0;
        sum   = '0;
        cand  = '0;
        found = 1'b0;
        // Scan N positions starting at ptr, wrapping modulo N.
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            cand = sum[PW-1:0];
            if (enable && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/butterfly_output_allocator.sv
// rtl/butterfly_output_allocator.sv - per-output switch allocator with wormhole lock and credits
module butterfly_output_allocator
    import noc_alloc_pkg::*;
#(
    parameter int K                 = 2,
    parameter int FLIT_BUFFER_DEPTH = 4,
    parameter int IDX_WIDTH         = clog2_min1(K),
    parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [K-1:0]            req,
    input  logic [K-1:0]            is_tail,
    input  logic                    credit_in,
    output logic [K-1:0]            grant,
    output logic [IDX_WIDTH-1:0]    grant_idx,
    output logic                    send_out,
    output logic                    is_tail_out,
    output logic [CREDIT_WIDTH-1:0] credit_count,
    output logic                    locked,
    output logic                    credit_err
);

    localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
    localparam logic [IDX_WIDTH-1:0]    LAST_IDX   = IDX_WIDTH'(K - 1);

    alloc_state_e           state, state_next;
    logic [IDX_WIDTH-1:0]   owner, owner_next;
    logic [IDX_WIDTH-1:0]   rr_ptr, rr_ptr_next;
    logic [CREDIT_WIDTH-1:0] credit_next;
    logic                   err_next;
    logic                   can_send;
    logic                   arb_enable;
    logic [K-1:0]           arb_grant;
    logic [IDX_WIDTH-1:0]   arb_idx;

    assign can_send   = (credit_count != '0);
    assign arb_enable = can_send && (state == ALLOC_IDLE);

    generate
        if (K == 1) begin : g_single
            assign arb_grant = req & {K{arb_enable}};
            assign arb_idx   = '0;
        end else begin : g_arb
            rr_arbiter #(
                .N  (K),
                .PW (IDX_WIDTH)
            ) u_arb (
                .req    (req),
                .ptr    (rr_ptr),
                .enable (arb_enable),
                .grant  (arb_grant),
                .idx    (arb_idx)
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ALLOC_IDLE;
            owner        <= '0;
            rr_ptr       <= '0;
            credit_count <= CREDIT_MAX;
            credit_err   <= 1'b0;
        end else begin
            state        <= state_next;
            owner        <= owner_next;
            rr_ptr       <= rr_ptr_next;
            credit_count <= credit_next;
            credit_err   <= err_next;
        end
    end

    always_comb begin
        state_next  = state;
        owner_next  = owner;
        rr_ptr_next = rr_ptr;
        credit_next = credit_count;
        err_next    = credit_err;
        grant       = '0;
        grant_idx   = '0;

        if (state == ALLOC_LOCKED) begin
            grant_idx = owner;
            if (req[owner] && can_send) begin
                grant[owner] = 1'b1;
            end
        end else begin
            grant     = arb_grant;
            grant_idx = arb_idx;
        end

        if (rst) begin
            grant     = '0;
            grant_idx = '0;
        end

        send_out    = |grant;
        is_tail_out = send_out && is_tail[grant_idx];
        locked      = (state == ALLOC_LOCKED) && !rst;

        // Winner of an IDLE grant advances the pointer; a non-tail flit opens a packet lock.
        if (send_out) begin
            if (state == ALLOC_IDLE) begin
                rr_ptr_next = (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_WIDTH'(1);
                if (!is_tail_out) begin
                    state_next = ALLOC_LOCKED;
                    owner_next = grant_idx;
                end
            end else if (is_tail_out) begin
                state_next = ALLOC_IDLE;
            end
        end

        if (send_out && !credit_in) begin
            credit_next = credit_count - CREDIT_WIDTH'(1);
        end else if (!send_out && credit_in) begin
            if (credit_count == CREDIT_MAX) begin
                err_next = 1'b1;
            end else begin
                credit_next = credit_count + CREDIT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_butterfly_output_allocator.sv
// tb/tb_butterfly_output_allocator.sv - scoreboard bench with reference model for the output allocator
module tb_butterfly_output_allocator;

    localparam int K     = 2;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [1:0] is_tail;
    logic       credit_in;
    logic [1:0] grant;
    logic [0:0] grant_idx;
    logic       send_out;
    logic       is_tail_out;
    logic [2:0] credit_count;
    logic       locked;
    logic       credit_err;

    butterfly_output_allocator #(
        .K                 (K),
        .FLIT_BUFFER_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .is_tail      (is_tail),
        .credit_in    (credit_in),
        .grant        (grant),
        .grant_idx    (grant_idx),
        .send_out     (send_out),
        .is_tail_out  (is_tail_out),
        .credit_count (credit_count),
        .locked       (locked),
        .credit_err   (credit_err)
    );

    typedef struct {
        logic       rst;
        logic [1:0] grant;
        int         idx;
        logic       send;
        logic       tail;
        int         cc;
        logic       lk;
        logic       err;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    bit m_locked  = 0;
    int m_owner   = 0;
    int m_ptr     = 0;
    int m_credits = DEPTH;
    bit m_err     = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive(input logic [1:0] r, input logic [1:0] t, input logic c, input logic rs);
        exp_t e;
        int   win;
        int   cand;
        @(posedge clk);
        #1;
        req = r; is_tail = t; credit_in = c; rst = rs;
        e.rst = rs; e.grant = 2'b00; e.idx = 0; e.send = 0; e.tail = 0;
        e.cc = m_credits; e.err = m_err; e.lk = rs ? 1'b0 : m_locked;
        if (rs) begin
            q.push_back(e);
            m_locked = 0; m_owner = 0; m_ptr = 0; m_credits = DEPTH; m_err = 0;
            return;
        end
        win = -1;
        if (m_credits > 0) begin
            if (m_locked) begin
                if (r[m_owner]) win = m_owner;
            end else begin
                for (int i = 0; i < K; i++) begin
                    cand = (m_ptr + i) % K;
                    if (win < 0 && r[cand]) win = cand;
                end
            end
        end
        if (win >= 0) begin
            e.grant[win] = 1'b1;
            e.idx  = win;
            e.send = 1'b1;
            e.tail = t[win];
            if (!m_locked) begin
                m_ptr = (win + 1) % K;
                if (!t[win]) begin
                    m_locked = 1;
                    m_owner  = win;
                end
            end else if (t[win]) begin
                m_locked = 0;
            end
        end
        if (c && win < 0) begin
            if (m_credits == DEPTH) m_err = 1;
            else m_credits++;
        end else if (!c && win >= 0) begin
            m_credits--;
        end
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        bit   bad;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                bad = (grant !== e.grant) || (send_out !== e.send) || (is_tail_out !== e.tail) ||
                      (credit_count !== 3'(e.cc)) || (locked !== e.lk) || (credit_err !== e.err) ||
                      ((e.send || e.rst) && (grant_idx !== 1'(e.idx)));
                if (bad) begin
                    miscompares++;
                    $display("FAIL vec%0d: got grant=%b idx=%0d send=%b tail=%b cc=%0d locked=%b err=%b; expected grant=%b idx=%0d send=%b tail=%b cc=%0d locked=%b err=%b",
                             vectors, grant, grant_idx, send_out, is_tail_out, credit_count, locked, credit_err,
                             e.grant, e.idx, e.send, e.tail, e.cc, e.lk, e.err);
                end
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1; req = 2'b00; is_tail = 2'b00; credit_in = 1'b0;
        drive(2'b00, 2'b00, 0, 1);
        drive(2'b00, 2'b00, 0, 1);

        // Round-robin single-flit packets until credits run out.
        repeat (6) drive(2'b11, 2'b11, 0, 0);
        repeat (4) drive(2'b00, 2'b00, 1, 0);

        // Input1 three-flit packet while input0 keeps requesting.
        drive(2'b10, 2'b00, 1, 0);
        drive(2'b11, 2'b00, 1, 0);
        drive(2'b11, 2'b10, 1, 0);
        drive(2'b01, 2'b01, 1, 0);

        // Owner 0 with a two-cycle bubble while input1 requests.
        drive(2'b01, 2'b00, 1, 0);
        drive(2'b10, 2'b00, 1, 0);
        drive(2'b10, 2'b00, 1, 0);
        drive(2'b01, 2'b01, 1, 0);

        // Drain to zero credits, return one, then spend it.
        repeat (4) drive(2'b01, 2'b01, 0, 0);
        drive(2'b01, 2'b01, 1, 0);
        drive(2'b01, 2'b01, 0, 0);

        // Simultaneous send and credit at two credits, then overflow.
        drive(2'b00, 2'b00, 1, 0);
        drive(2'b00, 2'b00, 1, 0);
        drive(2'b01, 2'b01, 1, 0);
        drive(2'b00, 2'b00, 1, 0);
        drive(2'b00, 2'b00, 1, 0);
        drive(2'b00, 2'b00, 1, 0);
        drive(2'b00, 2'b00, 0, 0);

        // Reset mid-packet at one credit, then input1 requests.
        drive(2'b01, 2'b00, 0, 0);
        drive(2'b01, 2'b00, 0, 0);
        drive(2'b01, 2'b00, 0, 0);
        drive(2'b01, 2'b00, 0, 1);
        drive(2'b10, 2'b10, 0, 0);
        drive(2'b10, 2'b10, 0, 0);

        for (int n = 0; n < 600; n++) begin
            drive(2'($urandom), 2'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
        end

        drive(2'b00, 2'b00, 0, 0);
        for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
